// File: rtl/minimig_autoconfig_chain_if.sv
// CPU-side config-window bus shared by the autoconfig sequencer and its host.
// master drives address/data/strobes, slave returns the combinational read nibble word.
interface minimig_autoconfig_chain_if;
   logic        clk7_en;
   logic [8:1]  address_in;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        rd;
   logic        hwr;
   logic        lwr;
   logic        sel;

   modport master (
      output clk7_en, address_in, data_in, rd, hwr, lwr, sel,
      input  data_out
   );

   modport slave (
      input  clk7_en, address_in, data_in, rd, hwr, lwr, sel,
      output data_out
   );
endinterface

// File: rtl/minimig_autoconfig_chain.sv
// Port-driven Zorro II/III autoconfig chain: presents eligible slots in index order at 0xE80000.
// Reads are combinational; scanning takes one clk per slot, bus writes advance only on clk7_en.
module minimig_autoconfig_chain #(
   parameter int NUM_BOARDS = 4,
   parameter int IDX_W      = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   minimig_autoconfig_chain_if.slave  bus,
   input  logic                       m68020,
   input  logic [NUM_BOARDS-1:0]      board_enable,
   input  logic [NUM_BOARDS-1:0]      board_z3,
   input  logic [8*NUM_BOARDS-1:0]    er_type,
   input  logic [8*NUM_BOARDS-1:0]    er_product,
   input  logic [8*NUM_BOARDS-1:0]    er_flags,
   input  logic [16*NUM_BOARDS-1:0]   er_manuf,
   input  logic [32*NUM_BOARDS-1:0]   er_serial,
   output logic [NUM_BOARDS-1:0]      board_configured,
   output logic [NUM_BOARDS-1:0]      board_shutup,
   output logic [16*NUM_BOARDS-1:0]   board_base,
   output logic [IDX_W-1:0]           active_board,
   output logic                       autoconfig_done
);

   localparam int                NSLOT    = 1 << IDX_W;
   localparam logic [IDX_W-1:0]  NULL_IDX = IDX_W'(NUM_BOARDS);

   typedef enum logic [1:0] {ST_INIT, ST_SCAN, ST_ACTIVE, ST_DONE} state_t;

   state_t                  r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_idx, w_idx_nxt;
   logic [IDX_W-1:0]        r_active, w_active_nxt;
   logic                    r_done;
   logic [NUM_BOARDS-1:0]   r_configured, r_shutup;
   logic [15:0]             r_base [NUM_BOARDS];

   logic [NSLOT-1:0]        w_elig;
   logic [7:0]              w_type, w_product, w_flags;
   logic [15:0]             w_manuf;
   logic [31:0]             w_serial;
   logic                    w_z3;
   logic [5:0]              w_woff;
   logic [7:0]              w_byte;
   logic [3:0]              w_nib_raw, w_nib;
   logic                    w_wr;
   logic                    w_cfg_set, w_shut_set;
   logic                    w_base_hi_we, w_base_lo_we;
   logic [7:0]              w_base_hi_dat, w_base_lo_dat;
   logic                    w_unused;

   // Padded to the full index range so the scan index can address it directly.
   assign w_elig   = NSLOT'(board_enable & (~board_z3 | {NUM_BOARDS{m68020}}));
   assign w_woff   = bus.address_in[6:1];
   assign w_wr     = bus.clk7_en & bus.sel & (bus.hwr | bus.lwr);
   assign w_unused = bus.rd;

   always_comb begin
      w_type    = 8'h00;
      w_product = 8'h00;
      w_flags   = 8'h00;
      w_manuf   = 16'h0000;
      w_serial  = 32'h0000_0000;
      w_z3      = 1'b0;
      for (int i = 0; i < NUM_BOARDS; i++) begin
         if (r_active == IDX_W'(i)) begin
            w_type    = er_type[8*i +: 8];
            w_product = er_product[8*i +: 8];
            w_flags   = er_flags[8*i +: 8];
            w_manuf   = er_manuf[16*i +: 16];
            w_serial  = er_serial[32*i +: 32];
            w_z3      = board_z3[i];
         end
      end
   end

   // Each descriptor byte occupies two words: high nibble first, low nibble second.
   always_comb begin
      w_byte = 8'h00;
      case (w_woff[4:1])
         4'h0:    w_byte = w_type;
         4'h1:    w_byte = w_product;
         4'h2:    w_byte = w_flags;
         4'h4:    w_byte = w_manuf[15:8];
         4'h5:    w_byte = w_manuf[7:0];
         4'h6:    w_byte = w_serial[31:24];
         4'h7:    w_byte = w_serial[23:16];
         4'h8:    w_byte = w_serial[15:8];
         4'h9:    w_byte = w_serial[7:0];
         default: w_byte = 8'h00;
      endcase
      w_nib_raw = w_woff[0] ? w_byte[3:0] : w_byte[7:4];
      w_nib     = 4'h0;
      if (r_state == ST_ACTIVE && bus.address_in[8:7] == 2'b00 && !w_woff[5])
         w_nib = (w_woff[4:1] == 4'h0) ? w_nib_raw : ~w_nib_raw;
   end

   assign bus.data_out = bus.sel ? {w_nib, 12'hfff} : 16'h0000;

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_active_nxt  = r_active;
      w_cfg_set     = 1'b0;
      w_shut_set    = 1'b0;
      w_base_hi_we  = 1'b0;
      w_base_lo_we  = 1'b0;
      w_base_hi_dat = bus.data_in[15:8];
      w_base_lo_dat = 8'h00;
      case (r_state)
         ST_INIT: begin
            w_state_nxt = ST_SCAN;
            w_idx_nxt   = '0;
         end
         ST_SCAN: begin
            if (r_idx >= NULL_IDX) begin
               w_state_nxt  = ST_DONE;
               w_active_nxt = NULL_IDX;
            end else if (w_elig[r_idx]) begin
               w_state_nxt  = ST_ACTIVE;
               w_active_nxt = r_idx;
            end else begin
               w_idx_nxt = r_idx + IDX_W'(1);
            end
         end
         ST_ACTIVE: begin
            if (w_wr) begin
               case (bus.address_in)
                  8'h24: if (!w_z3 && bus.hwr) begin
                     w_base_hi_we = 1'b1;
                     w_base_lo_we = 1'b1;
                     w_cfg_set    = 1'b1;
                     w_state_nxt  = ST_SCAN;
                     w_idx_nxt    = r_active + IDX_W'(1);
                  end
                  8'h22: if (w_z3 && bus.hwr) begin
                     w_base_hi_we  = 1'b1;
                     w_base_lo_we  = bus.lwr;
                     w_base_lo_dat = bus.data_in[7:0];
                     w_cfg_set     = 1'b1;
                     w_state_nxt   = ST_SCAN;
                     w_idx_nxt     = r_active + IDX_W'(1);
                  end
                  8'h23: if (w_z3) begin
                     w_base_lo_we  = 1'b1;
                     w_base_lo_dat = bus.data_in[15:8];
                  end
                  8'h26: begin
                     w_shut_set  = 1'b1;
                     w_state_nxt = ST_SCAN;
                     w_idx_nxt   = r_active + IDX_W'(1);
                  end
                  default: ;
               endcase
            end
         end
         ST_DONE: ;
         default: w_state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_INIT;
         r_idx    <= '0;
         r_active <= NULL_IDX;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_active <= w_active_nxt;
         r_done   <= r_done | (w_state_nxt == ST_DONE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_configured <= '0;
         r_shutup     <= '0;
         for (int i = 0; i < NUM_BOARDS; i++) r_base[i] <= 16'h0000;
      end else begin
         for (int i = 0; i < NUM_BOARDS; i++) begin
            if (r_active == IDX_W'(i)) begin
               if (w_cfg_set)    r_configured[i] <= 1'b1;
               if (w_shut_set)   r_shutup[i]     <= 1'b1;
               if (w_base_hi_we) r_base[i][15:8] <= w_base_hi_dat;
               if (w_base_lo_we) r_base[i][7:0]  <= w_base_lo_dat;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_BOARDS; g++) begin : g_base
      assign board_base[16*g +: 16] = r_base[g];
   end

   assign board_configured = r_configured;
   assign board_shutup     = r_shutup;
   assign active_board     = r_active;
   assign autoconfig_done  = r_done;

endmodule
